// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file (2 write, NRD read) with a self-clearing FSM
// Optional write-to-read bypass: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    input  logic              clr_req,
    output logic              ready
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] regs [DEPTH];

    // cnt starts at 1: address 0 is hardwired to zero and never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == {AW{1'b1}}) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= AW'(1);
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= AW'(1);
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; port 1 is written last so it wins on address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                if (we0 && (waddr0 != '0)) regs[waddr0] <= wdata0;
                if (we1 && (waddr1 != '0)) regs[waddr1] <= wdata1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] lane;

        assign a = raddr[i*AW +: AW];

        always_comb begin
            lane = '0;
            if (rst || !ready || !re[i] || (a == '0)) begin
                lane = '0;
`ifdef REGFILE_MP_BYPASS_EN
            end else if (we1 && (waddr1 == a)) begin
                lane = wdata1;
            end else if (we0 && (waddr0 == a)) begin
                lane = wdata0;
`endif
            end else begin
                lane = regs[a];
            end
        end

        assign rdata[i*DW +: DW] = lane;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        clr_req;
    logic        ready;

    int vectors = 0;
    int errors  = 0;

    regfile_mp #(.DW(32), .AW(5), .NRD(2)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata),
        .clr_req(clr_req), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input int i);
        return rdata[i*32 +: 32];
    endfunction

    task automatic write2(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        we0 = e0; waddr0 = a0; wdata0 = d0;
        we1 = e1; waddr1 = a1; wdata1 = d1;
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_reset;
        re = 2'b11; raddr = {5'd5, 5'd3};
        #3;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        vectors++;
        if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_clear_seq;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL clr_c0 ready got %b want 0", ready); end
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (ready !== (k == 31)) begin
                errors++; $display("FAIL clr_ready k=%0d got %b want %b", k, ready, k == 31);
            end
        end
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            re = 2'b11; raddr = {5'(31 - a), 5'(a)};
            #1;
            vectors++;
            if (rdata !== 64'd0) begin errors++; $display("FAIL clr_read a=%0d got %h want 0", a, rdata); end
            @(negedge clk);
        end
    endtask

    task automatic test_write_read;
        write2(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        re = 2'b11; raddr = {5'd5, 5'd5};
        #1;
        vectors++;
        if (lane(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr5_p0 got %h want deadbeef", lane(0)); end
        vectors++;
        if (lane(1) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr5_p1 got %h want deadbeef", lane(1)); end
        re = 2'b01;
        #1;
        vectors++;
        if (lane(1) !== 32'd0) begin errors++; $display("FAIL re_off_p1 got %h want 0", lane(1)); end
        vectors++;
        if (lane(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL re_on_p0 got %h want deadbeef", lane(0)); end
        @(negedge clk);
        write2(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        re = 2'b11; raddr = {5'd0, 5'd0};
        #1;
        vectors++;
        if (rdata !== 64'd0) begin errors++; $display("FAIL addr0 got %h want 0", rdata); end
        @(negedge clk);
    endtask

    task automatic test_same_addr;
        write2(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
        re = 2'b11; raddr = {5'd7, 5'd7};
        #1;
        vectors++;
        if (lane(0) !== 32'h22222222) begin errors++; $display("FAIL collide_p0 got %h want 22222222", lane(0)); end
        vectors++;
        if (lane(1) !== 32'h22222222) begin errors++; $display("FAIL collide_p1 got %h want 22222222", lane(1)); end
        @(negedge clk);
    endtask

    task automatic test_bypass;
        logic [31:0] exp1, exp2;
`ifdef REGFILE_MP_BYPASS_EN
        exp1 = 32'hA5A5A5A5; exp2 = 32'h3C3C3C3C;
`else
        exp1 = 32'h0BADF00D; exp2 = 32'hA5A5A5A5;
`endif
        write2(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 32'd0);
        re = 2'b11; raddr = {5'd9, 5'd9};
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
        #1;
        vectors++;
        if (lane(0) !== exp1) begin errors++; $display("FAIL byp_same_p0 got %h want %h", lane(0), exp1); end
        vectors++;
        if (lane(1) !== exp1) begin errors++; $display("FAIL byp_same_p1 got %h want %h", lane(1), exp1); end
        @(negedge clk);
        we0 = 1'b0;
        #1;
        vectors++;
        if (lane(0) !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_next got %h want a5a5a5a5", lane(0)); end
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0F0F0F0F;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h3C3C3C3C;
        #1;
        vectors++;
        if (lane(1) !== exp2) begin errors++; $display("FAIL byp_both got %h want %h", lane(1), exp2); end
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        #1;
        vectors++;
        if (lane(0) !== 32'h3C3C3C3C) begin errors++; $display("FAIL byp_both_next got %h want 3c3c3c3c", lane(0)); end
        @(negedge clk);
    endtask

    task automatic test_clear_during_writes;
        for (int a = 1; a < 32; a++) begin
            if (a % 2 == 1) write2(1'b1, 5'(a), 32'h10000000 + a, 1'b0, 5'd0, 32'd0);
            else            write2(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 32'h10000000 + a);
        end
        re = 2'b11; raddr = {5'd31, 5'd1};
        #1;
        vectors++;
        if (lane(0) !== 32'h10000001) begin errors++; $display("FAIL fill_a1 got %h want 10000001", lane(0)); end
        vectors++;
        if (lane(1) !== 32'h1000001F) begin errors++; $display("FAIL fill_a31 got %h want 1000001f", lane(1)); end
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL clrreq_c0 ready got %b want 0", ready); end
        for (int k = 1; k <= 31; k++) begin
            we0 = 1'b1; waddr0 = 5'd2;  wdata0 = 32'hEEEE0000 + k;
            we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'hDDDD0000 + k;
            clr_req = (k == 5);
            @(negedge clk);
            we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
            #1;
            vectors++;
            if (ready !== (k == 31)) begin
                errors++; $display("FAIL clrreq_ready k=%0d got %b want %b", k, ready, k == 31);
            end
        end
        for (int a = 0; a < 32; a++) begin
            re = 2'b11; raddr = {5'(31 - a), 5'(a)};
            #1;
            vectors++;
            if (rdata !== 64'd0) begin errors++; $display("FAIL clrreq_read a=%0d got %h want 0", a, rdata); end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_clear;
        write2(1'b1, 5'd20, 32'h00000044, 1'b0, 5'd0, 32'd0);
        re = 2'b11; raddr = {5'd20, 5'd20};
        #1;
        vectors++;
        if (lane(0) !== 32'h44) begin errors++; $display("FAIL pre_rst got %h want 44", lane(0)); end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_idle ready got %b want 0", ready); end
        vectors++;
        if (rdata !== 64'd0) begin errors++; $display("FAIL rst_idle rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid ready got %b want 0", ready); end
        vectors++;
        if (rdata !== 64'd0) begin errors++; $display("FAIL rst_mid rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_rel_c0 ready got %b want 0", ready); end
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (ready !== (k == 31)) begin
                errors++; $display("FAIL rst_rel_ready k=%0d got %b want %b", k, ready, k == 31);
            end
        end
        #1;
        vectors++;
        if (rdata !== 64'd0) begin errors++; $display("FAIL rst_rel_read got %h want 0", rdata); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0;
        test_reset;
        test_clear_seq;
        test_write_read;
        test_same_addr;
        test_bypass;
        test_clear_during_writes;
        test_rst_mid_clear;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
